// File: rtl/ram_uart_bus_ctrl.sv
`timescale 1ns/1ps
// Sequential controller for the external SRAM bank and memory-mapped UART on a shared data bus.
// Latency: SRAM 2+WAIT_CYC cycles, UART adds handshake wait cycles, status read 1 cycle.
// Busy while not IDLE; requests are sampled only in IDLE. Optional macro UART_TIMEOUT_EN bounds the UART wait.
module ram_uart_bus_ctrl #(
  parameter int          ADDR_W         = 18,
  parameter int          DATA_W         = 16,
  parameter int          WAIT_CYC       = 1,
  parameter logic [15:0] UART_DATA_ADDR = 16'hBF00,
  parameter logic [15:0] UART_STAT_ADDR = 16'hBF01,
  parameter int          TIMEOUT        = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_i,
  input  logic              sel_uart_i,
  input  logic              isread_i,
  input  logic              iswrite_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] data_i,
  output logic [DATA_W-1:0] rdata_o,
  output logic              ready_o,
  output logic              busy_o,
  output logic              err_o,
  output logic [ADDR_W-1:0] ram_addr_o,
  inout  wire  [DATA_W-1:0] ram_data_io,
  output logic              ram_oe_o,
  output logic              ram_we_o,
  output logic              ram_en_o,
  output logic              uart_rdn_o,
  output logic              uart_wrn_o,
  input  logic              data_ready_i,
  input  logic              tbre_i,
  input  logic              tsre_i
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_SETUP  = 3'd1;
  localparam logic [2:0] S_UWAIT  = 3'd2;
  localparam logic [2:0] S_ACCESS = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

  logic [2:0]        r_state;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_rdata;
  logic              r_write;
  logic              r_uart;
  logic              r_stat;
  logic [3:0]        r_cnt;

  logic w_one_op;
  logic w_is_data;
  logic w_is_stat;
  logic w_accept;
  logic w_uart_ok;
  logic w_access;
  logic w_drive;
  logic w_timeout;

  // Request qualification: exactly one op, and UART space only at a known register.
  assign w_one_op  = isread_i ^ iswrite_i;
  assign w_is_data = (addr_i[15:0] == UART_DATA_ADDR);
  assign w_is_stat = (addr_i[15:0] == UART_STAT_ADDR);
  assign w_accept  = req_i && w_one_op && (!sel_uart_i || w_is_data || w_is_stat);

  // UART handshake condition for the latched direction.
  assign w_uart_ok = r_write ? (tbre_i & tsre_i) : data_ready_i;

`ifdef UART_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] r_tcnt;

  assign w_timeout = (r_tcnt == TW'(TIMEOUT - 1));

  // Wait-cycle counter, cleared in SETUP and advanced in each unsatisfied UWAIT cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_tcnt <= '0;
    end else if (r_state == S_SETUP) begin
      r_tcnt <= '0;
    end else if (r_state == S_UWAIT && !w_uart_ok && !w_timeout) begin
      r_tcnt <= r_tcnt + 1'b1;
    end
  end
`else
  assign w_timeout = 1'b0;
`endif

  logic r_err;

  // Main FSM plus request latches, access counter, read capture and error flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_write <= 1'b0;
      r_uart  <= 1'b0;
      r_stat  <= 1'b0;
      r_cnt   <= '0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_err <= 1'b0;
          if (w_accept) begin
            r_addr  <= addr_i;
            r_wdata <= data_i;
            r_write <= iswrite_i;
            r_uart  <= sel_uart_i;
            r_stat  <= sel_uart_i && w_is_stat;
            r_cnt   <= '0;
            if (sel_uart_i && w_is_stat) begin
              // Status is a register snapshot, no bus cycle needed.
              if (isread_i) begin
                r_rdata <= {{(DATA_W-2){1'b0}}, data_ready_i, tbre_i & tsre_i};
              end
              r_state <= S_DONE;
            end else begin
              r_state <= S_SETUP;
            end
          end
        end
        S_SETUP: begin
          r_state <= r_uart ? S_UWAIT : S_ACCESS;
        end
        S_UWAIT: begin
          if (w_uart_ok) begin
            r_state <= S_ACCESS;
          end else if (w_timeout) begin
            r_err   <= 1'b1;
            r_state <= S_DONE;
          end
        end
        S_ACCESS: begin
          if (r_cnt == 4'(WAIT_CYC - 1)) begin
            if (!r_write) begin
              r_rdata <= ram_data_io;
            end
            r_state <= S_DONE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Strobes decode straight from state so an async reset releases them at once.
  assign w_access   = (r_state == S_ACCESS);
  assign ram_oe_o   = !(w_access && !r_uart && !r_write);
  assign ram_we_o   = !(w_access && !r_uart &&  r_write);
  assign uart_rdn_o = !(w_access &&  r_uart && !r_write);
  assign uart_wrn_o = !(w_access &&  r_uart &&  r_write);
  assign ram_en_o   = !(!r_uart && (r_state != S_IDLE));

  // Write data is driven from SETUP through DONE for hold; reads and status never drive.
  assign w_drive     = (r_state != S_IDLE) && r_write && !r_stat;
  assign ram_data_io = w_drive ? r_wdata : {DATA_W{1'bz}};
  assign ram_addr_o  = r_addr;

  assign rdata_o = r_rdata;
  assign ready_o = (r_state == S_DONE);
  assign busy_o  = (r_state != S_IDLE);
  assign err_o   = (r_state == S_DONE) && r_err;

endmodule

// File: tb/tb_ram_uart_bus_ctrl.sv
`timescale 1ns/1ps
module tb_ram_uart_bus_ctrl;
  localparam int AW = 18;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          req_i = 1'b0;
  logic          sel_uart_i = 1'b0;
  logic          isread_i = 1'b0;
  logic          iswrite_i = 1'b0;
  logic [AW-1:0] addr_i = '0;
  logic [DW-1:0] data_i = '0;
  logic          data_ready_i = 1'b0;
  logic          tbre_i = 1'b0;
  logic          tsre_i = 1'b0;
  logic [DW-1:0] rdata_o;
  logic          ready_o, busy_o, err_o;
  logic [AW-1:0] ram_addr_o;
  wire  [DW-1:0] ram_data_io;
  logic          ram_oe_o, ram_we_o, ram_en_o, uart_rdn_o, uart_wrn_o;

  always #5 clk = ~clk;

  ram_uart_bus_ctrl #(
    .ADDR_W(AW), .DATA_W(DW), .WAIT_CYC(1),
    .UART_DATA_ADDR(16'hBF00), .UART_STAT_ADDR(16'hBF01), .TIMEOUT(8)
  ) dut (
    .clk(clk), .rst(rst), .req_i(req_i), .sel_uart_i(sel_uart_i),
    .isread_i(isread_i), .iswrite_i(iswrite_i), .addr_i(addr_i), .data_i(data_i),
    .rdata_o(rdata_o), .ready_o(ready_o), .busy_o(busy_o), .err_o(err_o),
    .ram_addr_o(ram_addr_o), .ram_data_io(ram_data_io),
    .ram_oe_o(ram_oe_o), .ram_we_o(ram_we_o), .ram_en_o(ram_en_o),
    .uart_rdn_o(uart_rdn_o), .uart_wrn_o(uart_wrn_o),
    .data_ready_i(data_ready_i), .tbre_i(tbre_i), .tsre_i(tsre_i)
  );

  // Undriven bus floats high, so a floating bus reads as FFFF.
  for (genvar g = 0; g < DW; g++) begin : g_pu
    pullup (ram_data_io[g]);
  end

  // Small SRAM and UART receive models.
  logic [DW-1:0] mem [16];
  logic [DW-1:0] uart_rx_q = 16'h0041;
  logic          tb_drv_en;
  logic [DW-1:0] tb_drv_val;
  assign tb_drv_en   = (!ram_oe_o && !ram_en_o) || !uart_rdn_o;
  assign tb_drv_val  = !uart_rdn_o ? uart_rx_q : mem[ram_addr_o[3:0]];
  assign ram_data_io = tb_drv_en ? tb_drv_val : {DW{1'bz}};

  always @(posedge clk) begin
    if (!ram_we_o && !ram_en_o) mem[ram_addr_o[3:0]] <= ram_data_io;
  end

  int total = 0;
  int bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [4:0] strobes();
    return {ram_oe_o, ram_we_o, ram_en_o, uart_rdn_o, uart_wrn_o};
  endfunction

  task automatic issue(input logic uart, input logic rd, input logic wr,
                       input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_i = 1'b1; sel_uart_i = uart; isread_i = rd; iswrite_i = wr;
    addr_i = a; data_i = d;
  endtask

  task automatic drop();
    req_i = 1'b0; isread_i = 1'b0; iswrite_i = 1'b0; sel_uart_i = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int rdy_cyc;
    int low_cnt;
    int err_seen;
    logic [DW-1:0] rd_at_rdy;
    for (int i = 0; i < 16; i++) mem[i] = '0;

    // Reset state.
    #12;
    chk("rst_strobes", strobes(), 5'b11111);
    chk("rst_rdata", rdata_o, 16'h0000);
    chk("rst_flags", {ready_o, busy_o, err_o}, 3'b000);
    chk("rst_bus", ram_data_io, 16'hFFFF);
    rst = 1'b1;
    step();

    // SRAM write 00123 <- BEEF.
    issue(1'b0, 1'b0, 1'b1, 18'h00123, 16'hBEEF);
    step(); drop();
    chk("wr_c1_en_we", {ram_en_o, ram_we_o, busy_o, ready_o}, 4'b0110);
    chk("wr_c1_bus", ram_data_io, 16'hBEEF);
    chk("wr_c1_addr", ram_addr_o, 18'h00123);
    step();
    chk("wr_c2_we_low", {ram_en_o, ram_we_o, ram_oe_o, ready_o}, 4'b0010);
    chk("wr_c2_bus", ram_data_io, 16'hBEEF);
    step();
    chk("wr_c3_ready", {ready_o, busy_o, ram_we_o, ram_en_o}, 4'b1110);
    chk("wr_c3_bus", ram_data_io, 16'hBEEF);
    step();
    chk("wr_c4_idle", {ready_o, busy_o, ram_en_o}, 3'b001);
    chk("wr_c4_bus", ram_data_io, 16'hFFFF);
    chk("wr_mem", mem[3], 16'hBEEF);

    // SRAM read of the same address.
    issue(1'b0, 1'b1, 1'b0, 18'h00123, 16'h1111);
    step(); drop();
    chk("rd_c1", {ram_oe_o, ram_en_o, ready_o}, 3'b100);
    chk("rd_c1_bus", ram_data_io, 16'hFFFF);
    step();
    chk("rd_c2_oe_low", {ram_oe_o, ram_we_o, ready_o}, 3'b010);
    step();
    chk("rd_c3_ready", {ready_o, ram_oe_o}, 2'b11);
    chk("rd_c3_rdata", rdata_o, 16'hBEEF);
    chk("rd_c3_bus", ram_data_io, 16'hFFFF);
    step();

    // UART write to BF00, transmitter busy for cycles 1..5.
    tbre_i = 1'b0; tsre_i = 1'b1;
    issue(1'b1, 1'b0, 1'b1, 18'h0BF00, 16'h0055);
    rdy_cyc = 0; low_cnt = 0;
    for (int k = 1; k <= 20; k++) begin
      step();
      if (k == 1) drop();
      if (k == 6) tbre_i = 1'b1;
      if (!uart_wrn_o) begin
        low_cnt++;
        chk("uw_bus", ram_data_io, 16'h0055);
        chk("uw_wrn_cycle", k, 7);
      end
      if (ready_o) begin rdy_cyc = k; break; end
    end
    chk("uw_ready_cycle", rdy_cyc, 8);
    chk("uw_wrn_low_cnt", low_cnt, 1);
    step();

    // UART read from BF00, receive data arrives in cycle 3.
    data_ready_i = 1'b0;
    issue(1'b1, 1'b1, 1'b0, 18'h0BF00, 16'h0000);
    rdy_cyc = 0; low_cnt = 0; err_seen = 0; rd_at_rdy = '0;
    for (int k = 1; k <= 20; k++) begin
      step();
      if (k == 1) drop();
      if (k == 3) data_ready_i = 1'b1;
      if (!uart_rdn_o) low_cnt++;
      if (err_o) err_seen++;
      if (ready_o) begin rdy_cyc = k; rd_at_rdy = rdata_o; break; end
    end
    chk("ur_ready_cycle", rdy_cyc, 5);
    chk("ur_rdn_low_cnt", low_cnt, 1);
    chk("ur_rdata", rd_at_rdy, 16'h0041);
    chk("ur_no_err", err_seen, 0);
    step();

    // Status read: data_ready=1, tbre=1, tsre=0.
    tsre_i = 1'b0;
    issue(1'b1, 1'b1, 1'b0, 18'h0BF01, 16'h0000);
    step(); drop();
    chk("st_ready", {ready_o, busy_o}, 2'b11);
    chk("st_rdata", rdata_o, 16'h0002);
    chk("st_strobes", strobes(), 5'b11111);
    chk("st_bus", ram_data_io, 16'hFFFF);
    step();
    chk("st_idle", {ready_o, busy_o}, 2'b00);

    // Ignored requests: both ops, neither op, unmapped UART address.
    issue(1'b0, 1'b1, 1'b1, 18'h00007, 16'h1234);
    step();
    chk("ig_both", {ready_o, busy_o, strobes()}, 7'b0011111);
    issue(1'b0, 1'b0, 1'b0, 18'h00007, 16'h1234);
    step();
    chk("ig_none", {ready_o, busy_o, strobes()}, 7'b0011111);
    issue(1'b1, 1'b1, 1'b0, 18'h0BF05, 16'h0000);
    step(); drop();
    chk("ig_bf05", {ready_o, busy_o, strobes()}, 7'b0011111);
    step();
    chk("ig_after", {ready_o, busy_o}, 2'b00);

`ifdef UART_TIMEOUT_EN
    // UART read that never becomes ready: 8 UWAIT cycles then error.
    data_ready_i = 1'b0;
    issue(1'b1, 1'b1, 1'b0, 18'h0BF00, 16'h0000);
    rdy_cyc = 0; low_cnt = 0; err_seen = 0;
    for (int k = 1; k <= 30; k++) begin
      step();
      if (k == 1) drop();
      if (!uart_rdn_o) low_cnt++;
      if (ready_o) begin rdy_cyc = k; err_seen = int'(err_o); break; end
    end
    chk("to_ready_cycle", rdy_cyc, 10);
    chk("to_err", err_seen, 1);
    chk("to_no_strobe", low_cnt, 0);
    chk("to_rdata_kept", rdata_o, 16'h0002);
    step();
    chk("to_err_pulse", {err_o, ready_o}, 2'b00);
`endif

    // Reset asserted mid-ACCESS of an SRAM write.
    issue(1'b0, 1'b0, 1'b1, 18'h00005, 16'hCAFE);
    step(); drop();
    step();
    chk("rm_we_low", ram_we_o, 1'b0);
    #2 rst = 1'b0;
    #1;
    chk("rm_strobes", strobes(), 5'b11111);
    chk("rm_bus", ram_data_io, 16'hFFFF);
    chk("rm_flags", {ready_o, busy_o, err_o}, 3'b000);
    chk("rm_rdata", rdata_o, 16'h0000);
    step();
    rst = 1'b1;
    step(); step();
    chk("rm_no_write", mem[5], 16'h0000);
    chk("rm_idle", {busy_o, ready_o, strobes()}, 7'b0011111);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
